// File: rtl/cache_refill_if.sv
// Bus bundle between the refill engine, the CPU miss path, next-level memory and the data RAM.
// Widths come from the codebase macros `IDX, `OFS and `BLK (defaults below when not predefined).
`ifndef IDX
`define IDX 4
`endif
`ifndef OFS
`define OFS 2
`endif
`ifndef BLK
`define BLK (32*(1<<`OFS))
`endif

interface cache_refill_if;
  logic              miss_valid;
  logic [31:0]       miss_addr;
  logic              busy;
  logic              done;
  logic              crit_valid;
  logic [31:0]       crit_data;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [`IDX-1:0]   ram_index;
  logic [`OFS-1:0]   ram_offset;
  logic [`BLK-1:0]   ram_data_in;
  logic              ram_write;

  // master is the refill engine, slave is everything around it
  modport master (
    input  miss_valid, miss_addr, mem_rdata, mem_ready,
    output busy, done, crit_valid, crit_data, mem_req, mem_addr,
           ram_index, ram_offset, ram_data_in, ram_write
  );

  modport slave (
    output miss_valid, miss_addr, mem_rdata, mem_ready,
    input  busy, done, crit_valid, crit_data, mem_req, mem_addr,
           ram_index, ram_offset, ram_data_in, ram_write
  );
endinterface

// File: rtl/cache_refill.sv
// Cache line refill engine: fetches one line word by word, forwards the missed word, writes the line.
// Define REFILL_CRIT_FIRST_EN for critical-word-first fetch order; default is sequential from word 0.
`ifndef IDX
`define IDX 4
`endif
`ifndef OFS
`define OFS 2
`endif
`ifndef BLK
`define BLK (32*(1<<`OFS))
`endif

module cache_refill (
  input logic            clock,
  input logic            reset,
  cache_refill_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t              state;
  logic [31:`OFS+2]    line_base;
  logic [`OFS-1:0]     word;
  logic [`OFS-1:0]     ptr;
  logic [`OFS-1:0]     count;
  logic [`BLK-1:0]     buffer;
  logic [`BLK-1:0]     beat_buf;
  logic [`OFS-1:0]     start_ptr;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^bus.miss_addr[1:0];

`ifdef REFILL_CRIT_FIRST_EN
  assign start_ptr = bus.miss_addr[`OFS+1:2];
`else
  assign start_ptr = '0;
`endif

  // Buffer with the current beat merged in, so WRITE sees the last word without an extra cycle
  always_comb begin
    beat_buf = buffer;
    beat_buf[{ptr, 5'd0} +: 32] = bus.mem_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      line_base       <= '0;
      word            <= '0;
      ptr             <= '0;
      count           <= '0;
      buffer          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.crit_valid  <= 1'b0;
      bus.crit_data   <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.ram_index   <= '0;
      bus.ram_offset  <= '0;
      bus.ram_data_in <= '0;
      bus.ram_write   <= 1'b0;
    end else begin
      bus.crit_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.ram_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_valid) begin
            line_base    <= bus.miss_addr[31:`OFS+2];
            word         <= bus.miss_addr[`OFS+1:2];
            ptr          <= start_ptr;
            count        <= '0;
            bus.busy     <= 1'b1;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= {bus.miss_addr[31:`OFS+2], start_ptr, 2'b00};
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            buffer <= beat_buf;
            ptr    <= ptr + 1'b1;
            count  <= count + 1'b1;
            if (ptr == word) begin
              bus.crit_valid <= 1'b1;
              bus.crit_data  <= bus.mem_rdata;
            end
            // All-ones count marks the final beat of the line
            if (&count) begin
              state           <= WRITE;
              bus.mem_req     <= 1'b0;
              bus.mem_addr    <= '0;
              bus.ram_write   <= 1'b1;
              bus.done        <= 1'b1;
              bus.ram_index   <= line_base[`OFS+`IDX+1:`OFS+2];
              bus.ram_offset  <= word;
              bus.ram_data_in <= beat_buf;
            end else begin
              bus.mem_addr <= {line_base, ptr + 1'b1, 2'b00};
            end
          end
        end
        WRITE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
